// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
package uart_tx_scheduler_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned v;
        res = 0;
        v   = (value > 1) ? value - 1 : 0;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    // Field width helper: never narrower than one bit.
    function automatic int unsigned width_of(input int unsigned count);
        return (clog2(count) > 0) ? clog2(count) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Byte handshake between the scheduler and the shared uart_tx serializer.
interface uart_tx_scheduler_if;
    import uart_tx_scheduler_pkg::*;

    logic              o_tx_start;
    logic [BYTE_W-1:0] o_tx_data;
    logic              i_tx_done;

    modport master (
        output o_tx_start,
        output o_tx_data,
        input  i_tx_done
    );

    modport slave (
        input  o_tx_start,
        input  o_tx_data,
        output i_tx_done
    );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping modulo NREQ.
module uart_tx_scheduler_rr_arbiter
    import uart_tx_scheduler_pkg::*;
#(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt_c,
    output logic [PTR_W-1:0] idx_c
);

    always_comb begin
        logic found;
        gnt_c = '0;
        idx_c = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req[(32'(ptr) + i) % NREQ]) begin
                found                             = 1'b1;
                gnt_c[(32'(ptr) + i) % NREQ]      = 1'b1;
                idx_c                             = PTR_W'((32'(ptr) + i) % NREQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx serializer among NREQ requesters, streaming each granted word LSB byte first.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned WORD_W = 32
) (
    input  logic                                     i_clk,
    input  logic                                     i_reset,
    input  logic [NREQ-1:0]                          i_req,
    input  logic [NREQ*WORD_W-1:0]                   i_word,
    input  logic [NREQ*width_of(WORD_W/BYTE_W)-1:0]  i_len,
    output logic [NREQ-1:0]                          o_grant,
    output logic [NREQ-1:0]                          o_done,
    output logic                                     o_busy,
    uart_tx_scheduler_if.master                      tx
);

    localparam int unsigned NBYTES = WORD_W / BYTE_W;
    localparam int unsigned LEN_W  = width_of(NBYTES);
    localparam int unsigned PTR_W  = width_of(NREQ);

    state_t              state, state_d;
    logic [WORD_W-1:0]   shreg, shreg_d;
    logic [LEN_W-1:0]    rem, rem_d;
    logic [PTR_W-1:0]    owner, owner_d;
    logic [PTR_W-1:0]    rr_ptr, rr_ptr_d;
    logic [NREQ-1:0]     grant_q, grant_d;
    logic [NREQ-1:0]     done_q, done_d;
    logic                busy_q, busy_d;
    logic                tx_start_q, tx_start_d;
    logic [BYTE_W-1:0]   tx_data_q, tx_data_d;

    logic [NREQ-1:0]     win_gnt_c;
    logic [PTR_W-1:0]    win_idx_c;
    logic [WORD_W-1:0]   win_word_c;
    logic [LEN_W-1:0]    win_len_c;
    logic [WORD_W-1:0]   shreg_shift_c;

    uart_tx_scheduler_rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req   (i_req),
        .ptr   (rr_ptr),
        .gnt_c (win_gnt_c),
        .idx_c (win_idx_c)
    );

    assign win_word_c    = i_word[32'(win_idx_c) * WORD_W +: WORD_W];
    assign win_len_c     = i_len[32'(win_idx_c) * LEN_W +: LEN_W];
    assign shreg_shift_c = shreg >> BYTE_W;

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            rem        <= '0;
            owner      <= '0;
            rr_ptr     <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state      <= state_d;
            shreg      <= shreg_d;
            rem        <= rem_d;
            owner      <= owner_d;
            rr_ptr     <= rr_ptr_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Next-state and output decode; pulses default low, data holds.
    always_comb begin
        state_d    = state;
        shreg_d    = shreg;
        rem_d      = rem;
        owner_d    = owner;
        rr_ptr_d   = rr_ptr;
        grant_d    = '0;
        done_d     = '0;
        busy_d     = busy_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;

        case (state)
            ST_IDLE: begin
                if (|i_req) begin
                    state_d    = ST_WAIT;
                    shreg_d    = win_word_c;
                    rem_d      = win_len_c;
                    owner_d    = win_idx_c;
                    grant_d    = win_gnt_c;
                    tx_start_d = 1'b1;
                    tx_data_d  = win_word_c[BYTE_W-1:0];
                    busy_d     = 1'b1;
                end
            end
            ST_WAIT: begin
                if (tx.i_tx_done) begin
                    if (rem != '0) begin
                        shreg_d    = shreg_shift_c;
                        rem_d      = rem - LEN_W'(1);
                        tx_start_d = 1'b1;
                        tx_data_d  = shreg_shift_c[BYTE_W-1:0];
                    end else begin
                        // Move the pointer past the finished owner so others win next.
                        done_d   = NREQ'(1) << owner;
                        rr_ptr_d = (owner == PTR_W'(NREQ - 1)) ? '0 : owner + PTR_W'(1);
                        busy_d   = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_grant       = grant_q;
    assign o_done        = done_q;
    assign o_busy        = busy_q;
    assign tx.o_tx_start = tx_start_q;
    assign tx.o_tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler with a fixed-latency serializer model.
module tb_uart_tx_scheduler;

    localparam int unsigned SER_LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req = '0;
    logic [31:0] word0 = '0;
    logic [31:0] word1 = '0;
    logic [1:0]  len0 = '0;
    logic [1:0]  len1 = '0;
    logic [1:0]  o_grant;
    logic [1:0]  o_done;
    logic        o_busy;
    logic        model_done = 1'b0;
    logic        spur_done = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cyc = -10;

    logic [7:0] exp_byte[$];
    logic [1:0] exp_grant[$];
    logic [1:0] exp_done[$];

    uart_tx_scheduler_if sif ();
    assign sif.i_tx_done = model_done | spur_done;

    uart_tx_scheduler #(
        .NREQ   (2),
        .WORD_W (32)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .i_req   (req),
        .i_word  ({word1, word0}),
        .i_len   ({len1, len0}),
        .o_grant (o_grant),
        .o_done  (o_done),
        .o_busy  (o_busy),
        .tx      (sif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // kind 0: grant, 1: done, 2: tx_start
    task automatic wait_evt(input int kind, input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            case (kind)
                0:       seen = |o_grant;
                1:       seen = |o_done;
                default: seen = sif.o_tx_start;
            endcase
        end
        if (!seen) flag({"timeout waiting for ", name});
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_grant"}, 32'(o_grant), 32'h0);
        check({name, "_done"}, 32'(o_done), 32'h0);
        check({name, "_busy"}, 32'(o_busy), 32'h0);
        check({name, "_start"}, 32'(sif.o_tx_start), 32'h0);
        check({name, "_data"}, 32'(sif.o_tx_data), 32'h0);
    endtask

    // Serializer model: done pulse SER_LAT cycles after each start, cleared by reset.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            model_done = 1'b0;
            if (reset) begin
                cnt = 0;
            end else begin
                if (cnt != 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        model_done = 1'b1;
                        done_cyc   = cyc;
                    end
                end
                if (sif.o_tx_start) cnt = SER_LAT;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (o_grant != '0) begin
                    if (exp_grant.size() == 0) flag("unexpected grant");
                    else check("grant", 32'(o_grant), 32'(exp_grant.pop_front()));
                    check("busy_at_grant", 32'(o_busy), 32'h1);
                end
                if (sif.o_tx_start) begin
                    if (exp_byte.size() == 0) flag("unexpected tx_start");
                    else check("tx_data", 32'(sif.o_tx_data), 32'(exp_byte.pop_front()));
                    if (o_grant == '0) check("start_after_done", 32'(cyc - done_cyc), 32'h1);
                end
                if (o_done != '0) begin
                    if (exp_done.size() == 0) flag("unexpected done");
                    else check("done", 32'(o_done), 32'(exp_done.pop_front()));
                    check("busy_at_done", 32'(o_busy), 32'h0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global timeout (cycle %0d)", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // 1: single 4-byte word from requester 0
        word0 = 32'hA1B2C3D4; len0 = 2'd3;
        exp_grant.push_back(2'b01);
        exp_byte.push_back(8'hD4); exp_byte.push_back(8'hC3);
        exp_byte.push_back(8'hB2); exp_byte.push_back(8'hA1);
        exp_done.push_back(2'b01);
        req = 2'b01;
        wait_evt(0, "t1 grant");
        req = 2'b00;
        wait_evt(1, "t1 done");
        @(negedge clk);
        check("t1_busy_after", 32'(o_busy), 32'h0);

        // 2: both held from rr_ptr=0, one byte each -> 0,1,0
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        word0 = 32'h11223344; word1 = 32'h55667788; len0 = 2'd0; len1 = 2'd0;
        exp_grant.push_back(2'b01); exp_byte.push_back(8'h44); exp_done.push_back(2'b01);
        exp_grant.push_back(2'b10); exp_byte.push_back(8'h88); exp_done.push_back(2'b10);
        exp_grant.push_back(2'b01); exp_byte.push_back(8'h44); exp_done.push_back(2'b01);
        req = 2'b11;
        wait_evt(0, "t2 grant a");
        wait_evt(0, "t2 grant b");
        wait_evt(0, "t2 grant c");
        req = 2'b00;
        wait_evt(1, "t2 done");

        // 3: requester 1 alone, two bytes, then pointer must be back at 0
        word1 = 32'h0000_55AA; len1 = 2'd1;
        exp_grant.push_back(2'b10);
        exp_byte.push_back(8'hAA); exp_byte.push_back(8'h55);
        exp_done.push_back(2'b10);
        req = 2'b10;
        wait_evt(0, "t3 grant");
        req = 2'b00;
        wait_evt(1, "t3 done");
        len1 = 2'd0;
        exp_grant.push_back(2'b01); exp_byte.push_back(8'h44); exp_done.push_back(2'b01);
        req = 2'b11;
        wait_evt(0, "t3 ptr grant");
        req = 2'b00;
        wait_evt(1, "t3 ptr done");

        // 4: spurious done in IDLE, then req1 toggled during a req0 transfer
        @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t4_spur_start", 32'(sif.o_tx_start), 32'h0);
            check("t4_spur_grant", 32'(o_grant), 32'h0);
            @(negedge clk);
        end
        word0 = 32'hDEADBEEF; len0 = 2'd3;
        exp_grant.push_back(2'b01);
        exp_byte.push_back(8'hEF); exp_byte.push_back(8'hBE);
        exp_byte.push_back(8'hAD); exp_byte.push_back(8'hDE);
        exp_done.push_back(2'b01);
        req = 2'b01;
        wait_evt(0, "t4 grant");
        req = 2'b10;
        repeat (3) @(negedge clk);
        req = 2'b00;
        wait_evt(1, "t4 done");

        // 5: reset between 2nd and 3rd byte, then a fresh request
        word1 = 32'h01020304; len1 = 2'd3;
        exp_grant.push_back(2'b10);
        exp_byte.push_back(8'h04); exp_byte.push_back(8'h03);
        req = 2'b10;
        wait_evt(0, "t5 grant");
        req = 2'b00;
        wait_evt(2, "t5 second start");
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("t5_reset");
        @(negedge clk);
        reset = 1'b0;
        word0 = 32'h000000C5; len0 = 2'd0;
        exp_grant.push_back(2'b01); exp_byte.push_back(8'hC5); exp_done.push_back(2'b01);
        req = 2'b01;
        wait_evt(0, "t5 fresh grant");
        req = 2'b00;
        wait_evt(1, "t5 fresh done");

        repeat (8) @(negedge clk);
        check("left_grants", 32'(exp_grant.size()), 32'h0);
        check("left_bytes", 32'(exp_byte.size()), 32'h0);
        check("left_dones", 32'(exp_done.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
